r_ptr_empty_fwft: RTL

R_PTR_EMPTY_FWFT -- requirements
Module: r_ptr_empty_fwft

---
 rtl/r_ptr_empty_fwft_if.sv | 30 +++
 rtl/r_ptr_empty_fwft.sv | 89 ++++++++
 2 files changed

// File: rtl/r_ptr_empty_fwft_if.sv
// rtl/r_ptr_empty_fwft_if.sv - read-side FIFO pointer/FWFT bus
//
// Groups the write-pointer input, memory read port, consumer handshake and
// status outputs of the read-side FIFO control block.
//   slave  : the read-side controller (r_ptr_empty_fwft)
//   master : the surrounding FIFO memory, write domain and consumer
interface r_ptr_empty_fwft_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        wq_wptr;
    logic [DATA_W-1:0] mem_rdata;
    logic              dout_ready;
    logic [2:0]        rd_addr;
    logic [3:0]        rd_ptr;
    logic              mem_empty;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [3:0]        rd_level;
    logic              rd_err;

    modport slave (
        input  wq_wptr, mem_rdata, dout_ready,
        output rd_addr, rd_ptr, mem_empty, dout, dout_valid, rd_level, rd_err
    );

    modport master (
        output wq_wptr, mem_rdata, dout_ready,
        input  rd_addr, rd_ptr, mem_empty, dout, dout_valid, rd_level, rd_err
    );
endinterface

// File: rtl/r_ptr_empty_fwft.sv
// rtl/r_ptr_empty_fwft.sv - async FIFO read pointer, empty flag and FWFT output stage
//
// Ports:
//   rd_clk          read-domain clock
//   rd_rst_n        synchronous active-low reset
//   bus (slave)     wq_wptr    Gray write pointer from the write domain (async)
//                   mem_rdata  memory data at rd_addr (combinational)
//                   dout_ready consumer accepts dout this cycle
//                   rd_addr    memory read address (rd_bin[2:0])
//                   rd_ptr     registered Gray read pointer to the write side
//                   mem_empty  memory holds no unread words
//                   dout       first-word-fall-through output register
//                   dout_valid dout holds an unconsumed word
//                   rd_level   words left in memory, excluding the dout word
//                   rd_err     sticky flag for an illegal pointer distance
module r_ptr_empty_fwft #(
    parameter int DATA_W = 8
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    r_ptr_empty_fwft_if.slave    bus
);

    logic [3:0]        rq1_wptr;
    logic [3:0]        rq2_wptr;
    logic [3:0]        rd_bin;
    logic [3:0]        rd_ptr_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic [3:0]        rd_level_q;
    logic              rd_err_q;

    logic              mem_empty;
    logic              fetch;
    logic [3:0]        rd_bin_next;
    logic [3:0]        wbin_s;
    logic [3:0]        diff;

    assign mem_empty   = (rd_ptr_q == rq2_wptr);
    // The output register refills whenever it is empty or being drained,
    // so a consume and a fetch can share one edge.
    assign fetch       = !mem_empty && (!dout_valid_q || bus.dout_ready);
    assign rd_bin_next = fetch ? (rd_bin + 4'd1) : rd_bin;

    assign wbin_s = {rq2_wptr[3],
                     rq2_wptr[3] ^ rq2_wptr[2],
                     rq2_wptr[3] ^ rq2_wptr[2] ^ rq2_wptr[1],
                     ^rq2_wptr};
    // Distance against the post-fetch pointer so the word moving into dout
    // is no longer counted as being in memory.
    assign diff = wbin_s - rd_bin_next;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rq1_wptr     <= 4'd0;
            rq2_wptr     <= 4'd0;
            rd_bin       <= 4'd0;
            rd_ptr_q     <= 4'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rd_level_q   <= 4'd0;
            rd_err_q     <= 1'b0;
        end else begin
            rq1_wptr   <= bus.wq_wptr;
            rq2_wptr   <= rq1_wptr;
            rd_bin     <= rd_bin_next;
            rd_ptr_q   <= rd_bin_next ^ (rd_bin_next >> 1);
            rd_level_q <= diff;
            if (diff > 4'd8) begin
                rd_err_q <= 1'b1;
            end
            if (fetch) begin
                dout_q       <= bus.mem_rdata;
                dout_valid_q <= 1'b1;
            end else if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rd_addr    = rd_bin[2:0];
    assign bus.rd_ptr     = rd_ptr_q;
    assign bus.mem_empty  = mem_empty;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.rd_level   = rd_level_q;
    assign bus.rd_err     = rd_err_q;

endmodule
